// File: rtl/opcode_sequencer.sv
// Issue-side opcode sequencer: the opcode field of IF/ID. Expands CALL/RET/RTI into two
// micro-opcodes, injects the 11110/11111 interrupt pair and bubbles after redirects.
module opcode_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] fetchedOpCode,
  input  logic       fetchValid,
  input  logic       interrupt,
  input  logic       flush,
  output logic [4:0] opCode,
  output logic       makeMeBubble,
  output logic       pcHold,
  output logic       intAck
);

  localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(FLUSH_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [2:0] StPass  = 3'd0;
  localparam logic [2:0] StCall2 = 3'd1;
  localparam logic [2:0] StRet2  = 3'd2;
  localparam logic [2:0] StRti2  = 3'd3;
  localparam logic [2:0] StInt2  = 3'd4;
  localparam logic [2:0] StFlush = 3'd5;

  localparam logic [4:0] OpNop   = 5'b00000;
  localparam logic [4:0] OpCall  = 5'b11000;
  localparam logic [4:0] OpCall2 = 5'b11001;
  localparam logic [4:0] OpRet   = 5'b11010;
  localparam logic [4:0] OpRet2  = 5'b11011;
  localparam logic [4:0] OpRti   = 5'b11100;
  localparam logic [4:0] OpRti2  = 5'b11101;
  localparam logic [4:0] OpIntA  = 5'b11110;
  localparam logic [4:0] OpIntB  = 5'b11111;

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : gBadFlushCycles
    $fatal(1, "opcode_sequencer: FLUSH_CYCLES must be in 1..3");
  end

  logic [2:0]      stateQ, stateD;
  logic [CntW-1:0] cntQ, cntD;
  logic            intPendingQ, intPendingD;
  logic [4:0]      opD;
  logic            bubD, ackD, takeInt;

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    opD     = OpNop;
    bubD    = 1'b0;
    ackD    = 1'b0;
    pcHold  = 1'b1;
    takeInt = 1'b0;

    case (stateQ)
      StPass: begin
        pcHold = 1'b0;
        if (flush) begin
          bubD = 1'b1;
        end else if (intPendingQ) begin
          // Fetched word stays at the fetch output and is issued after the ISR returns.
          opD     = OpIntA;
          ackD    = 1'b1;
          pcHold  = 1'b1;
          takeInt = 1'b1;
          stateD  = StInt2;
        end else if (fetchValid) begin
          case (fetchedOpCode)
            OpCall: begin
              opD    = OpCall;
              stateD = StCall2;
            end
            OpRet: begin
              opD    = OpRet;
              stateD = StRet2;
            end
            OpRti: begin
              opD    = OpRti;
              stateD = StRti2;
            end
            OpCall2, OpRet2, OpRti2, OpIntA, OpIntB: opD = OpNop;
            default: opD = fetchedOpCode;
          endcase
        end
      end
      StCall2: begin
        opD    = OpCall2;
        stateD = StFlush;
        cntD   = CntInit;
      end
      StRet2: begin
        opD    = OpRet2;
        stateD = StFlush;
        cntD   = CntInit;
      end
      StRti2: begin
        opD    = OpRti2;
        stateD = StFlush;
        cntD   = CntInit;
      end
      StInt2: begin
        opD    = OpIntB;
        stateD = StFlush;
        cntD   = CntInit;
      end
      StFlush: begin
        bubD = 1'b1;
        if (cntQ <= CntOne) begin
          stateD = StPass;
          cntD   = '0;
        end else begin
          cntD = cntQ - CntOne;
        end
      end
      default: begin
        stateD = StPass;
        cntD   = '0;
      end
    endcase

    // A new request in the take cycle keeps the flag set.
    intPendingD = interrupt | (intPendingQ & ~takeInt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ       <= StPass;
      cntQ         <= '0;
      intPendingQ  <= 1'b0;
      opCode       <= OpNop;
      makeMeBubble <= 1'b0;
      intAck       <= 1'b0;
    end else begin
      stateQ       <= stateD;
      cntQ         <= cntD;
      intPendingQ  <= intPendingD;
      opCode       <= opD;
      makeMeBubble <= bubD;
      intAck       <= ackD;
    end
  end

endmodule

// File: tb/tb_opcode_sequencer.sv
// Bench for opcode_sequencer: two instances (FLUSH_CYCLES 1 and 3) checked every cycle against
// a queue-based issue model, plus directed literal expectations from the test plan.
module tb_opcode_sequencer;

  logic       clk;
  logic       rst;
  logic [4:0] fetchedOpCode;
  logic       fetchValid;
  logic       interrupt;
  logic       flush;

  logic [4:0] opA, opB;
  logic       bubA, bubB, holdA, holdB, ackA, ackB;
  logic       preHoldA, preHoldB;

  int nChecks = 0;
  int nFails  = 0;

  opcode_sequencer #(.FLUSH_CYCLES(1)) uA (
    .clk(clk), .rst(rst), .fetchedOpCode(fetchedOpCode), .fetchValid(fetchValid),
    .interrupt(interrupt), .flush(flush), .opCode(opA), .makeMeBubble(bubA),
    .pcHold(holdA), .intAck(ackA)
  );

  opcode_sequencer #(.FLUSH_CYCLES(3)) uB (
    .clk(clk), .rst(rst), .fetchedOpCode(fetchedOpCode), .fetchValid(fetchValid),
    .interrupt(interrupt), .flush(flush), .opCode(opB), .makeMeBubble(bubB),
    .pcHold(holdB), .intAck(ackB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  // Issue model: an empty queue means the sequencer is free to look at fetch; anything a
  // PASS decision commits to (second parts, bubbles) is queued and drained one per cycle.
  logic [5:0] pend[2][8];  // {bubble, opcode}
  int         pendLen[2];
  logic       mPend[2];
  logic [4:0] mOp[2];
  logic       mBub[2];
  logic       mAck[2];
  int         fcOf[2];
  logic       started = 1'b0;

  task automatic pushTail(input int i, input logic [4:0] second);
    pend[i][pendLen[i]] = {1'b0, second};
    pendLen[i]++;
    for (int k = 0; k < fcOf[i]; k++) begin
      pend[i][pendLen[i]] = {1'b1, 5'b00000};
      pendLen[i]++;
    end
  endtask

  task automatic modelStep(input int i);
    logic take;
    mAck[i] = 1'b0;
    mBub[i] = 1'b0;
    mOp[i]  = 5'b00000;
    if (rst) begin
      pendLen[i] = 0;
      mPend[i]   = 1'b0;
    end else if (pendLen[i] > 0) begin
      {mBub[i], mOp[i]} = pend[i][0];
      for (int k = 0; k < 7; k++) pend[i][k] = pend[i][k+1];
      pendLen[i]--;
      mPend[i] = mPend[i] | interrupt;
    end else begin
      take = !flush && mPend[i];
      if (flush) begin
        mBub[i] = 1'b1;
      end else if (mPend[i]) begin
        mOp[i]  = 5'b11110;
        mAck[i] = 1'b1;
        pushTail(i, 5'b11111);
      end else if (fetchValid) begin
        if (fetchedOpCode == 5'b11000 || fetchedOpCode == 5'b11010 ||
            fetchedOpCode == 5'b11100) begin
          mOp[i] = fetchedOpCode;
          pushTail(i, fetchedOpCode + 5'd1);
        end else if (fetchedOpCode[4:3] == 2'b11) begin
          mOp[i] = 5'b00000;
        end else begin
          mOp[i] = fetchedOpCode;
        end
      end
      mPend[i] = interrupt | (mPend[i] & !take);
    end
  endtask

  initial begin
    logic [4:0] dOp;
    logic       dBub, dAck, dHold, eHold;
    fcOf[0] = 1;
    fcOf[1] = 3;
    pendLen[0] = 0;
    pendLen[1] = 0;
    forever begin
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < 2; i++) begin
          dOp   = (i == 0) ? opA : opB;
          dBub  = (i == 0) ? bubA : bubB;
          dAck  = (i == 0) ? ackA : ackB;
          dHold = (i == 0) ? holdA : holdB;
          eHold = (pendLen[i] > 0) || (!flush && mPend[i]);
          chk($sformatf("model opCode inst%0d t=%0t", i, $time), {3'b0, dOp}, {3'b0, mOp[i]});
          chk($sformatf("model bubble inst%0d t=%0t", i, $time), {7'b0, dBub}, {7'b0, mBub[i]});
          chk($sformatf("model intAck inst%0d t=%0t", i, $time), {7'b0, dAck}, {7'b0, mAck[i]});
          chk($sformatf("model pcHold inst%0d t=%0t", i, $time), {7'b0, dHold}, {7'b0, eHold});
        end
      end
      modelStep(0);
      modelStep(1);
      if (rst) started = 1'b1;
    end
  end

  task automatic cyc(input logic v, input logic [4:0] op, input logic intr, input logic fl,
                     input logic r);
    rst           = r;
    fetchValid    = v;
    fetchedOpCode = op;
    interrupt     = intr;
    flush         = fl;
    #1;
    preHoldA = holdA;
    preHoldB = holdB;
    @(posedge clk);
    #1;
  endtask

  task automatic expA(input string nm, input logic [4:0] op, input logic bub, input logic ack);
    chk({nm, " A"}, {1'b0, ackA, bubA, opA}, {1'b0, ack, bub, op});
  endtask

  task automatic expB(input string nm, input logic [4:0] op, input logic bub, input logic ack);
    chk({nm, " B"}, {1'b0, ackB, bubB, opB}, {1'b0, ack, bub, op});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cyc(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1);
    expA("reset", 5'b00000, 1'b0, 1'b0);
    expB("reset", 5'b00000, 1'b0, 1'b0);

    // Plain pass-through
    cyc(1'b1, 5'b01001, 1'b0, 1'b0, 1'b0);
    expA("add", 5'b01001, 1'b0, 1'b0);
    chk("add hold", {7'b0, preHoldA}, 8'd0);
    cyc(1'b1, 5'b10001, 1'b0, 1'b0, 1'b0);
    expB("ldm", 5'b10001, 1'b0, 1'b0);

    // CALL with one flush bubble; flush during CALL2 must be ignored
    cyc(1'b1, 5'b11000, 1'b0, 1'b0, 1'b0);
    expA("call1", 5'b11000, 1'b0, 1'b0);
    chk("call1 hold", {7'b0, preHoldA}, 8'd0);
    cyc(1'b1, 5'b00001, 1'b0, 1'b1, 1'b0);
    expA("call2", 5'b11001, 1'b0, 1'b0);
    chk("call2 hold", {7'b0, preHoldA}, 8'd1);
    cyc(1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
    expA("call bubble", 5'b00000, 1'b1, 1'b0);
    chk("call bubble hold", {7'b0, preHoldA}, 8'd1);
    cyc(1'b1, 5'b00001, 1'b0, 1'b0, 1'b0);
    expA("call resume", 5'b00001, 1'b0, 1'b0);
    chk("call resume hold", {7'b0, preHoldA}, 8'd0);
    idle(4);

    // RTI with three bubbles, interrupt raised while 11101 is presented
    cyc(1'b1, 5'b11100, 1'b0, 1'b0, 1'b0);
    expB("rti1", 5'b11100, 1'b0, 1'b0);
    cyc(1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
    expB("rti2", 5'b11101, 1'b0, 1'b0);
    chk("rti2 hold", {7'b0, preHoldB}, 8'd1);
    cyc(1'b1, 5'b00010, 1'b1, 1'b0, 1'b0);
    expB("rti bubble1", 5'b00000, 1'b1, 1'b0);
    cyc(1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
    expB("rti bubble2", 5'b00000, 1'b1, 1'b0);
    cyc(1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
    expB("rti bubble3", 5'b00000, 1'b1, 1'b0);
    cyc(1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
    expB("int1", 5'b11110, 1'b0, 1'b1);
    chk("int1 hold", {7'b0, preHoldB}, 8'd1);
    cyc(1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
    expB("int2", 5'b11111, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
      expB($sformatf("int bubble%0d", k), 5'b00000, 1'b1, 1'b0);
    end
    cyc(1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
    expB("int resume", 5'b00010, 1'b0, 1'b0);
    chk("int resume hold", {7'b0, preHoldB}, 8'd0);
    idle(4);

    // Flush and interrupt together: flush first, fetched 01010 discarded
    cyc(1'b1, 5'b01010, 1'b1, 1'b1, 1'b0);
    expB("flush+int", 5'b00000, 1'b1, 1'b0);
    chk("flush+int hold", {7'b0, preHoldB}, 8'd0);
    cyc(1'b1, 5'b00011, 1'b0, 1'b0, 1'b0);
    expB("fi int1", 5'b11110, 1'b0, 1'b1);
    cyc(1'b1, 5'b00011, 1'b0, 1'b0, 1'b0);
    expB("fi int2", 5'b11111, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 5'b00011, 1'b0, 1'b0, 1'b0);
      expB($sformatf("fi bubble%0d", k), 5'b00000, 1'b1, 1'b0);
    end
    cyc(1'b1, 5'b00011, 1'b0, 1'b0, 1'b0);
    expB("fi resume", 5'b00011, 1'b0, 1'b0);
    idle(2);

    // Illegal internal code, then invalid fetch
    cyc(1'b1, 5'b11011, 1'b0, 1'b0, 1'b0);
    expB("illegal", 5'b00000, 1'b0, 1'b0);
    expA("illegal", 5'b00000, 1'b0, 1'b0);
    cyc(1'b0, 5'b00111, 1'b0, 1'b0, 1'b0);
    expB("invalid", 5'b00000, 1'b0, 1'b0);
    cyc(1'b1, 5'b00100, 1'b0, 1'b0, 1'b0);
    expB("after illegal", 5'b00100, 1'b0, 1'b0);

    // Reset during RET2 abandons the second part and the pending interrupt
    cyc(1'b1, 5'b11010, 1'b1, 1'b0, 1'b0);
    expB("ret1", 5'b11010, 1'b0, 1'b0);
    cyc(1'b1, 5'b00101, 1'b0, 1'b0, 1'b1);
    expB("ret reset", 5'b00000, 1'b0, 1'b0);
    cyc(1'b1, 5'b00101, 1'b0, 1'b0, 1'b0);
    expB("post reset", 5'b00101, 1'b0, 1'b0);
    expA("post reset", 5'b00101, 1'b0, 1'b0);
    chk("post reset hold", {7'b0, preHoldB}, 8'd0);
    cyc(1'b1, 5'b00110, 1'b0, 1'b0, 1'b0);
    expB("post reset 2", 5'b00110, 1'b0, 1'b0);

    // Interrupt held two cycles, RET/CALL mix and stray flushes, checked by the model
    cyc(1'b0, 5'b00000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 5'b00000, 1'b1, 1'b0, 1'b0);
    idle(14);
    cyc(1'b1, 5'b11010, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'b01111, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'b01111, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 5'b01111, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) cyc(1'b1, 5'(k + 3), 1'b0, (k == 6), 1'b0);
    cyc(1'b1, 5'b11111, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'b11110, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'b11000, 1'b0, 1'b0, 1'b0);
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/opcode_sequencer.md
Name: opcode_sequencer

Overview:
- Issue-side partner of the control unit: produces the 5-bit opCode and makeMeBubble that the control unit decodes.
- Sits between fetch and decode, and acts as the opcode field of the IF/ID register.
- Expands two-part instructions: CALL, RET and RTI are issued as two micro-opcodes.
- Injects the hardware interrupt pair 11110/11111, inserts bubbles after control-flow redirects, and stalls the PC while it does any of this.

Parameters:
- FLUSH_CYCLES, 1, bubbles inserted after a redirecting second part (11001, 11011, 11101, 11111); legal range 1..3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetchedOpCode  in  5  opcode field of the instruction word currently at the fetch output.
- fetchValid  in  1  fetchedOpCode is meaningful this cycle.
- interrupt  in  1  external interrupt request, level, sampled every cycle.
- flush  in  1  taken-branch (JZ/JN/JC/JMP) squash request from the branch unit.
- opCode  out  5  registered opcode to the control unit.
- makeMeBubble  out  1  registered; forces a control-unit bubble.
- pcHold  out  1  combinational; 1 means fetch must not advance the PC this cycle.
- intAck  out  1  registered; one-cycle pulse coinciding with opCode=11110.

Behaviour:
- Reset (clk edge with rst=1):
  - opCode=00000, makeMeBubble=0, intAck=0.
  - state=PASS, intPending=0, flush counter=0.
  - Reset mid-sequence abandons any partial sequence; no second part is issued afterwards.
- intPending:
  - Set on any cycle with interrupt=1.
  - Cleared in the cycle the sequencer transitions PASS->INT2, which is the cycle 11110 is registered.
  - Set has priority over clear.
- Latency: one cycle. The opcode chosen in cycle N appears on opCode in N+1.
- States: PASS, CALL2, RET2, RTI2, INT2, FLUSH.
- PASS, evaluated in this priority order:
  1. flush=1: register 00000 with bubble=1; fetched word discarded; pcHold=0; stay in PASS.
  2. intPending=1: register 11110 with intAck=1; pcHold=1 (fetched word kept for after the ISR); go to INT2.
  3. fetchValid=0: register 00000 with bubble=0; pcHold=0.
  4. fetched 11000: register 11000; go to CALL2.
  5. fetched 11010: register 11010; go to RET2.
  6. fetched 11100: register 11100; go to RTI2.
  7. fetched 11001, 11011, 11101, 11110 or 11111 (internal-only codes): treated as illegal; register 00000 with bubble=0.
  8. Any other code: passed through unchanged, bubble=0.
  - pcHold=0 in cases 1 and 3 through 8.
- Second-part states:
  - CALL2 registers 11001; RET2 registers 11011; RTI2 registers 11101; INT2 registers 11111.
  - pcHold=1 in all of them; bubble=0.
  - Each goes to FLUSH with counter=FLUSH_CYCLES.
- FLUSH:
  - Registers 00000 with bubble=1; pcHold=1; counter decrements each cycle.
  - Goes to PASS in the cycle the counter reaches 1.
- flush and interrupt outside PASS:
  - flush is ignored in every state except PASS.
  - interrupt is never taken outside PASS; it stays pending until the next PASS cycle.
- Simultaneous flush and intPending in PASS: the flush bubble is issued first; the interrupt is taken on the next PASS cycle.
- intAck is 1 only in the cycle opCode=11110 is presented. Back-to-back interrupt requests produce one 11110/11111 pair per pending edge window, never overlapping.
- The counter is clog2(FLUSH_CYCLES+1) bits and never wraps. FLUSH_CYCLES outside 1..3 is a configuration error; simulation fatal.

Test Plan:
1. After reset, fetch 01001 (ADD) then 10001 (LDM) with fetchValid=1 -> opCode 01001 then 10001 one cycle later each; bubble=0; pcHold=0 throughout.
2. Fetch 11000 (CALL), FLUSH_CYCLES=1 -> opCode sequence 11000, 11001, 00000(bubble=1), then the next fetched opcode. pcHold=1 for exactly 2 cycles following the CALL fetch cycle.
3. Fetch 11100 (RTI) with FLUSH_CYCLES=3 -> 11100, 11101, then three bubbles (bubble=1), then resume. Raise interrupt during the 11101 cycle -> 11110 (intAck=1), 11111, three bubbles, issued immediately after, before any fetched opcode.
4. In PASS: flush=1 and interrupt=1 in the same cycle with fetched 01010 -> bubble 00000, then 11110/11111, then 3 bubbles (FLUSH_CYCLES=3). 01010 is never issued, because it was discarded by the flush.
5. Fetch illegal 11011 -> opCode 00000 with bubble=0, state stays PASS. Fetch 00111 with fetchValid=0 -> 00000, bubble=0.
6. Assert rst for one cycle during RET2 (after 11010 issued) -> next opCode 00000, 11011 never appears, intPending cleared, next fetched opcode passes through normally.
